// File: rtl/hs_master_if.sv
// hs_master_if: 8-bit vaild/ready link between hs_master (transmitter) and slave (receiver).
`timescale 1ns/1ps

interface hs_master_if;
  logic       vaild;
  logic       ready;
  logic [7:0] master_data;

  modport master (
    output vaild,
    output master_data,
    input  ready
  );

  modport slave (
    input  vaild,
    input  master_data,
    output ready
  );
endinterface

// File: rtl/hs_master.sv
// hs_master: transmitting end of the vaild/ready byte link.
// Bytes from the local write port are queued in a DEPTH-entry FIFO and presented one at a
// time from a registered output stage.
// Optional build macro HS_MASTER_PATTERN_EN: replaces the write port with an incrementing
// byte generator for link bring-up.
`timescale 1ns/1ps

module hs_master #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [7:0]               wr_data_i,
  output logic                     full_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [15:0]              tx_cnt_o,
  hs_master_if.master              link
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e            state_q;
  logic [7:0]        data_q;
  logic [7:0]        mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q, level_d;
  logic              full_q;
  logic              overflow_q;
  logic [15:0]       tx_cnt_q;

  logic              push, pop, xfer, ovf_set, fifo_empty;
  logic [7:0]        push_data;

`ifdef HS_MASTER_PATTERN_EN
  logic [7:0] pat_q;
  logic       unused_wr;

  assign unused_wr = ^{wr_en_i, wr_data_i};
  assign push      = ~full_q;
  assign push_data = pat_q;
  assign ovf_set   = 1'b0;

  // Generator advances only when its byte is accepted, so the sequence has no gaps.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      pat_q <= 8'h00;
    end else if (push) begin
      pat_q <= pat_q + 8'd1;
    end
  end
`else
  assign push      = wr_en_i & ~full_q;
  assign push_data = wr_data_i;
  assign ovf_set   = wr_en_i & full_q;
`endif

  assign fifo_empty = (level_q == '0);
  assign xfer       = (state_q == StSend) & link.ready;
  // Head is loaded whenever the output register is empty or being emptied this edge.
  assign pop        = ~fifo_empty & ((state_q == StIdle) | link.ready);

  // Next FIFO occupancy; a simultaneous push and pop cancel out.
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // FIFO pointers, occupancy, full/overflow flags and transfer counter.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      tx_cnt_q   <= 16'h0000;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_d;
      full_q  <= (level_d == LvlW'(DEPTH));
      if (ovf_set) overflow_q <= 1'b1;
      if (xfer)    tx_cnt_q   <= tx_cnt_q + 16'd1;
    end
  end

  // Output stage: vaild is the state itself, so it never sees ready combinationally.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      data_q  <= 8'h00;
    end else begin
      if (pop) data_q <= mem_q[rd_ptr_q];
      unique case (state_q)
        StIdle:  if (pop) state_q <= StSend;
        StSend:  if (link.ready && fifo_empty) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign link.vaild       = (state_q == StSend);
  assign link.master_data = data_q;
  assign full_o           = full_q;
  assign overflow_o       = overflow_q;
  assign level_o          = level_q;
  assign tx_cnt_o         = tx_cnt_q;

endmodule

// File: tb/tb_hs_master.sv
// tb_hs_master: directed self-checking bench for hs_master (DEPTH = 4).
`timescale 1ns/1ps

module tb_hs_master;

  logic        sys_clk;
  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        full;
  logic        overflow;
  logic [2:0]  level;
  logic [15:0] tx_cnt;

  int n_cmp = 0;
  int n_err = 0;

  hs_master_if link_if ();

  hs_master #(.DEPTH(4)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .full_o     (full),
    .overflow_o (overflow),
    .level_o    (level),
    .tx_cnt_o   (tx_cnt),
    .link       (link_if.master)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; sample 1 ns later, away from the edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " vaild"},    {31'd0, link_if.vaild}, 32'd0);
    chk({tag, " data"},     {24'd0, link_if.master_data}, 32'h00);
    chk({tag, " full"},     {31'd0, full}, 32'd0);
    chk({tag, " overflow"}, {31'd0, overflow}, 32'd0);
    chk({tag, " level"},    {29'd0, level}, 32'd0);
    chk({tag, " tx_cnt"},   {16'd0, tx_cnt}, 32'd0);
  endtask

`ifdef HS_MASTER_PATTERN_EN
  initial begin
    logic [7:0] exp_b;
    int         n_rx;
    exp_b = 8'h00;
    n_rx  = 0;
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; link_if.ready = 1'b1;
    #1;
    chk_reset_vals("pat_reset");
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      // ready is held high, so every byte seen with vaild transfers at the next edge.
      if (link_if.vaild) begin
        chk("pat_byte", {24'd0, link_if.master_data}, {24'd0, exp_b});
        exp_b = exp_b + 8'd1;
        n_rx++;
      end
      tick();
    end
    chk("pat_tx_cnt", {16'd0, tx_cnt}, n_rx);
    chk("pat_overflow", {31'd0, overflow}, 32'd0);
    chk("pat_wrapped", {31'd0, (n_rx > 256) ? 1'b1 : 1'b0}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
`else
  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; link_if.ready = 1'b0;
    #1;
    chk_reset_vals("reset");
    tick();
    reset = 1'b0;
    tick();

    // Single byte into an empty block.
    wr_en = 1'b1; wr_data = 8'hA5; link_if.ready = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("single level1", {29'd0, level}, 32'd1);
    chk("single vaild0", {31'd0, link_if.vaild}, 32'd0);
    tick();
    chk("single vaild1", {31'd0, link_if.vaild}, 32'd1);
    chk("single data",   {24'd0, link_if.master_data}, 32'hA5);
    chk("single level0", {29'd0, level}, 32'd0);
    tick();
    chk("single vaild_drop", {31'd0, link_if.vaild}, 32'd0);
    chk("single tx_cnt",     {16'd0, tx_cnt}, 32'd1);

    // Burst with a long stall, then back-to-back drain.
    link_if.ready = 1'b0;
    wr_en = 1'b1; wr_data = 8'h10; tick();
    wr_data = 8'h11; tick();
    chk("burst push_pop level", {29'd0, level}, 32'd1);
    wr_data = 8'h12; tick();
    wr_data = 8'h13; tick();
    wr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall data",  {24'd0, link_if.master_data}, 32'h10);
      chk("stall vaild", {31'd0, link_if.vaild}, 32'd1);
      tick();
    end
    chk("stall level", {29'd0, level}, 32'd3);
    link_if.ready = 1'b1;
    tick(); chk("drain 11", {24'd0, link_if.master_data}, 32'h11);
    chk("drain vaild", {31'd0, link_if.vaild}, 32'd1);
    tick(); chk("drain 12", {24'd0, link_if.master_data}, 32'h12);
    tick(); chk("drain 13", {24'd0, link_if.master_data}, 32'h13);
    chk("drain vaild13", {31'd0, link_if.vaild}, 32'd1);
    tick(); chk("drain idle", {31'd0, link_if.vaild}, 32'd0);
    chk("burst tx_cnt", {16'd0, tx_cnt}, 32'd5);

    // Overfill while stalled: 1 in output register, 4 in FIFO, 6th rejected.
    link_if.ready = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'h20 + 8'(i);
      tick();
    end
    chk("ovf full",   {31'd0, full}, 32'd1);
    chk("ovf level4", {29'd0, level}, 32'd4);
    chk("ovf clear",  {31'd0, overflow}, 32'd0);
    wr_data = 8'h25; tick();
    wr_en = 1'b0;
    chk("ovf set",    {31'd0, overflow}, 32'd1);
    chk("ovf level",  {29'd0, level}, 32'd4);
    chk("ovf head",   {24'd0, link_if.master_data}, 32'h20);
    link_if.ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("ovf drain", {24'd0, link_if.master_data}, 32'h20 + i);
    end
    tick();
    chk("ovf drain end", {31'd0, link_if.vaild}, 32'd0);
    chk("ovf tx_cnt",    {16'd0, tx_cnt}, 32'd10);

    // Asynchronous reset with a byte presented and three queued.
    link_if.ready = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'h40 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    chk("mid vaild", {31'd0, link_if.vaild}, 32'd1);
    chk("mid level", {29'd0, level}, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    link_if.ready = 1'b1;
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    chk("post vaild",  {31'd0, link_if.vaild}, 32'd0);
    chk("post level",  {29'd0, level}, 32'd0);
    chk("post tx_cnt", {16'd0, tx_cnt}, 32'd0);

    // Full FIFO, ready and write in the same cycle: write rejected, one pop.
    link_if.ready = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'h30 + 8'(i);
      tick();
    end
    chk("fp full",   {31'd0, full}, 32'd1);
    chk("fp ovf0",   {31'd0, overflow}, 32'd0);
    wr_data = 8'h35; link_if.ready = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("fp level3", {29'd0, level}, 32'd3);
    chk("fp ovf1",   {31'd0, overflow}, 32'd1);
    chk("fp full0",  {31'd0, full}, 32'd0);
    chk("fp data",   {24'd0, link_if.master_data}, 32'h31);
    tick(); chk("fp 32", {24'd0, link_if.master_data}, 32'h32);
    tick(); chk("fp 33", {24'd0, link_if.master_data}, 32'h33);
    tick(); chk("fp 34", {24'd0, link_if.master_data}, 32'h34);
    tick(); chk("fp idle", {31'd0, link_if.vaild}, 32'd0);
    chk("fp tx_cnt", {16'd0, tx_cnt}, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
`endif

endmodule
